// File: rtl/uart_pkg.sv
// uart_pkg: shared frame/FIFO defaults, oversampling constants and FSM state types
// for the UART core and its FIFOs.
package uart_pkg;
   localparam int DBIT_DEF    = 8;
   localparam int SB_TICK_DEF = 16;
   localparam int FIFO_W_DEF  = 2;
   localparam int OS_TICK     = 16;
   localparam int MID_TICK    = 7;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: circular-buffer FIFO with registered full/empty flags and
// fall-through read data taken straight from the head slot.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = FIFO_W_DEF
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          rd_i,
   input  logic          wr_i,
   input  logic [DW-1:0] w_data_i,
   output logic          empty_o,
   output logic          full_o,
   output logic [DW-1:0] r_data_o
);
   logic [DW-1:0] mem_q [2**AW];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic          full_q, full_d, empty_q, empty_d, wr_en, rd_en;
   // A write into a full FIFO is only taken when a read frees the head slot in the same cycle.
   always_comb begin
      rd_en   = rd_i & ~empty_q;
      wr_en   = wr_i & (~full_q | rd_en);
      wp_d    = wr_en ? wp_q + AW'(1) : wp_q;
      rp_d    = rd_en ? rp_q + AW'(1) : rp_q;
      empty_d = (rd_en & ~wr_en) ? (rp_d == wp_q) : (wr_en & ~rd_en) ? 1'b0 : empty_q;
      full_d  = (wr_en & ~rd_en) ? (wp_d == rp_q) : (rd_en & ~wr_en) ? 1'b0 : full_q;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wp_q    <= '0;
         rp_q    <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (wr_en & ~reset_i) mem_q[wp_q] <= w_data_i;
   end
   assign empty_o  = empty_q;
   assign full_o   = full_q;
   assign r_data_o = mem_q[rp_q];
endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART, shared 16x baud generator, 4-deep TX/RX FIFOs.
// Define UART_LOOPBACK_EN to feed the RX engine from the internal tx line instead of rx_i.
module uart_core
   import uart_pkg::*;
#(
   parameter int DBIT    = DBIT_DEF,
   parameter int SB_TICK = SB_TICK_DEF,
   parameter int FIFO_W  = FIFO_W_DEF
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        rd_uart_i,
   input  logic        wr_uart_i,
   input  logic        rx_i,
   input  logic [7:0]  w_data_i,
   input  logic [10:0] dvsr_i,
   output logic        tx_full_o,
   output logic        rx_empty_o,
   output logic        tx_o,
   output logic [7:0]  r_data_o
);
   localparam int SW = $clog2(SB_TICK > OS_TICK ? SB_TICK : OS_TICK);
   localparam int NW = $clog2(DBIT);
   logic [10:0]   cnt_q, cnt_d;
   logic          s_tick, rx_in, tx_done_tick, rx_done_tick;
   logic          txf_empty, rxf_empty, unused_rxf_full;
   logic [7:0]    txf_data;
   tx_state_e     tx_st_q, tx_st_d;
   rx_state_e     rx_st_q, rx_st_d;
   logic [SW-1:0] tx_s_q, tx_s_d, rx_s_q, rx_s_d;
   logic [NW-1:0] tx_n_q, tx_n_d, rx_n_q, rx_n_d;
   logic [7:0]    tx_b_q, tx_b_d, rx_b_q, rx_b_d;
   logic          tx_q, tx_d;
   assign cnt_d  = (cnt_q == dvsr_i) ? '0 : cnt_q + 11'd1;
   assign s_tick = cnt_q == 11'd1;
`ifdef UART_LOOPBACK_EN
   logic unused_rx;
   assign unused_rx = rx_i;
   assign rx_in     = tx_q;
`else
   logic [1:0] sync_q;
   always_ff @(posedge clk_i) sync_q <= reset_i ? 2'b11 : {sync_q[0], rx_i};
   assign rx_in = sync_q[1];
`endif
   uart_fifo #(.DW(8), .AW(FIFO_W)) u_txf (
      .clk_i, .reset_i, .rd_i(tx_done_tick), .wr_i(wr_uart_i), .w_data_i,
      .empty_o(txf_empty), .full_o(tx_full_o), .r_data_o(txf_data)
   );
   uart_fifo #(.DW(8), .AW(FIFO_W)) u_rxf (
      .clk_i, .reset_i, .rd_i(rd_uart_i), .wr_i(rx_done_tick), .w_data_i(rx_b_q),
      .empty_o(rxf_empty), .full_o(unused_rxf_full), .r_data_o
   );
   // The head byte stays in the TX FIFO until its stop bit completes.
   always_comb begin
      tx_st_d      = tx_st_q;
      tx_s_d       = tx_s_q;
      tx_n_d       = tx_n_q;
      tx_b_d       = tx_b_q;
      tx_done_tick = 1'b0;
      unique case (tx_st_q)
         TX_IDLE: if (~txf_empty) begin
            tx_st_d = TX_START;
            tx_s_d  = '0;
            tx_b_d  = txf_data;
         end
         TX_START: if (s_tick) begin
            if (tx_s_q == SW'(OS_TICK - 1)) begin
               tx_st_d = TX_DATA;
               tx_s_d  = '0;
               tx_n_d  = '0;
            end else tx_s_d = tx_s_q + SW'(1);
         end
         TX_DATA: if (s_tick) begin
            if (tx_s_q == SW'(OS_TICK - 1)) begin
               tx_s_d = '0;
               tx_b_d = tx_b_q >> 1;
               if (tx_n_q == NW'(DBIT - 1)) tx_st_d = TX_STOP;
               else tx_n_d = tx_n_q + NW'(1);
            end else tx_s_d = tx_s_q + SW'(1);
         end
         TX_STOP: if (s_tick) begin
            if (tx_s_q == SW'(SB_TICK - 1)) begin
               tx_st_d      = TX_IDLE;
               tx_done_tick = 1'b1;
            end else tx_s_d = tx_s_q + SW'(1);
         end
      endcase
      tx_d = (tx_st_d == TX_START) ? 1'b0 : (tx_st_d == TX_DATA) ? tx_b_d[0] : 1'b1;
   end
   always_comb begin
      rx_st_d      = rx_st_q;
      rx_s_d       = rx_s_q;
      rx_n_d       = rx_n_q;
      rx_b_d       = rx_b_q;
      rx_done_tick = 1'b0;
      unique case (rx_st_q)
         RX_IDLE: if (~rx_in) begin
            rx_st_d = RX_START;
            rx_s_d  = '0;
         end
         RX_START: if (s_tick) begin
            if (rx_s_q == SW'(MID_TICK)) begin
               rx_st_d = rx_in ? RX_IDLE : RX_DATA;
               rx_s_d  = '0;
               rx_n_d  = '0;
            end else rx_s_d = rx_s_q + SW'(1);
         end
         RX_DATA: if (s_tick) begin
            if (rx_s_q == SW'(OS_TICK - 1)) begin
               rx_s_d = '0;
               rx_b_d = {rx_in, rx_b_q[7:1]};
               if (rx_n_q == NW'(DBIT - 1)) rx_st_d = RX_STOP;
               else rx_n_d = rx_n_q + NW'(1);
            end else rx_s_d = rx_s_q + SW'(1);
         end
         RX_STOP: if (s_tick) begin
            if (rx_s_q == SW'(SB_TICK - 1)) begin
               rx_st_d      = RX_IDLE;
               rx_done_tick = 1'b1;
            end else rx_s_d = rx_s_q + SW'(1);
         end
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q   <= '0;
         tx_st_q <= TX_IDLE;
         tx_s_q  <= '0;
         tx_n_q  <= '0;
         tx_b_q  <= '0;
         tx_q    <= 1'b1;
         rx_st_q <= RX_IDLE;
         rx_s_q  <= '0;
         rx_n_q  <= '0;
         rx_b_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         tx_st_q <= tx_st_d;
         tx_s_q  <= tx_s_d;
         tx_n_q  <= tx_n_d;
         tx_b_q  <= tx_b_d;
         tx_q    <= tx_d;
         rx_st_q <= rx_st_d;
         rx_s_q  <= rx_s_d;
         rx_n_q  <= rx_n_d;
         rx_b_q  <= rx_b_d;
      end
   end
   assign tx_o       = tx_q;
   assign rx_empty_o = rxf_empty;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scoreboard bench; stimulus queues expected bytes, independent monitors
// decode the tx line and drain the RX FIFO. Runs with dvsr=7 (8 clk/tick, 128 clk/bit).
module tb_uart_core;
   localparam int BIT = 128;
   logic        clk = 1'b0, reset_i = 1'b1, rd_uart = 1'b0, wr_uart = 1'b0, rx = 1'b1;
   logic [7:0]  w_data = '0;
   logic [10:0] dvsr = 11'd7;
   logic        tx_full, rx_empty, tx;
   logic [7:0]  r_data;
   logic [7:0]  tx_exp[$], rx_exp[$];
   logic        rx_drain = 1'b0;
   int          checks = 0, errors = 0;
   uart_core dut (
      .clk_i(clk), .reset_i(reset_i), .rd_uart_i(rd_uart), .wr_uart_i(wr_uart), .rx_i(rx),
      .w_data_i(w_data), .dvsr_i(dvsr), .tx_full_o(tx_full), .rx_empty_o(rx_empty),
      .tx_o(tx), .r_data_o(r_data)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask
   task automatic write_byte(input logic [7:0] b);
      @(negedge clk);
      wr_uart = 1'b1;
      w_data  = b;
      @(negedge clk);
      wr_uart = 1'b0;
   endtask
   task automatic send_byte(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (BIT) @(negedge clk);
      end
   endtask
   task automatic tick_period(input int exp);
      int n;
      n = 0;
      for (int i = 0; i < 5000 && !dut.s_tick; i++) @(negedge clk);
      do begin
         @(negedge clk);
         n++;
      end while (!dut.s_tick && n < 5000);
      chk("tick_period", 32'(n), 32'(exp));
   endtask
   task automatic drain(input int lim);
      int n;
      n = 0;
      while ((tx_exp.size() != 0 || rx_exp.size() != 0) && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(n < lim), 32'd1);
      repeat (200) @(negedge clk);
   endtask
   // tx line monitor: frame decoded from the falling edge, sampled mid-bit
   initial begin : tx_mon
      logic [9:0] f;
      bit ab;
      forever begin
         @(negedge clk);
         if (!reset_i && tx === 1'b0) begin
            ab = 1'b0;
            f  = '0;
            for (int c = 1; c <= 64 + 9 * BIT; c++) begin
               @(negedge clk);
               if (reset_i) ab = 1'b1;
               if (c >= 64 && (c - 64) % BIT == 0) f[(c - 64) / BIT] = tx;
            end
            if (!ab) begin
               if (tx_exp.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_unexpected: got frame %0h expected none", f[8:1]);
               end else begin
                  chk("tx_byte", 32'(f[8:1]), 32'(tx_exp.pop_front()));
                  chk("tx_framing", 32'({f[9], f[0]}), 32'd2);
               end
            end
         end
      end
   end
   initial begin : rx_mon
      forever begin
         @(negedge clk);
         if (rx_drain && !reset_i && !rx_empty) begin
            if (rx_exp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected: got byte %0h expected none", r_data);
            end else chk("rx_byte", 32'(r_data), 32'(rx_exp.pop_front()));
            rd_uart = 1'b1;
            @(negedge clk);
            rd_uart = 1'b0;
         end
      end
   end
   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic prev;
      bit seen;
      int n;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_tx_full", 32'(tx_full), 32'd0);
      chk("rst_rx_empty", 32'(rx_empty), 32'd1);
      dvsr = 11'd3;
      tick_period(4);
      dvsr = 11'd7;
      tick_period(8);
      tick_period(8);
      tx_exp.push_back(8'h55);
      write_byte(8'h55);
      chk("tx_after_1_edge", 32'(tx), 32'd1);
      @(negedge clk);
      chk("tx_after_2_edges", 32'(tx), 32'd0);
      drain(3000);
      repeat (500) @(negedge clk);
      tx_exp.push_back(8'hAA);
      write_byte(8'hAA);
      seen = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (tx_full) seen = 1'b1;
      end
      chk("tx_full_single", 32'(seen), 32'd0);
      drain(3000);
      foreach (tx_exp[i]) tx_exp.delete(i);
      tx_exp = '{8'hF0, 8'h0F, 8'h00, 8'hFF};
      write_byte(8'hF0);
      write_byte(8'h0F);
      write_byte(8'h00);
      chk("tx_full_3", 32'(tx_full), 32'd0);
      write_byte(8'hFF);
      chk("tx_full_4", 32'(tx_full), 32'd1);
      write_byte(8'h00);
      chk("tx_full_5", 32'(tx_full), 32'd1);
      prev = 1'b0;
      n = 0;
      while (tx_full && n < 3000) begin
         prev = dut.tx_done_tick;
         @(negedge clk);
         n++;
      end
      chk("full_fall_after_done", 32'(prev), 32'd1);
      chk("full_fall_queue", 32'(tx_exp.size()), 32'd3);
      drain(8000);
      repeat (1500) @(negedge clk);
      send_byte(8'hA5);
      chk("rx_not_empty_a5", 32'(rx_empty), 32'd0);
      rx_exp.push_back(8'hA5);
      rx_drain = 1'b1;
      drain(200);
      chk("rx_empty_after_rd", 32'(rx_empty), 32'd1);
      rx_drain = 1'b0;
      for (int i = 1; i <= 5; i++) send_byte(8'(i));
      chk("rx_not_empty_5", 32'(rx_empty), 32'd0);
      rx_exp = '{8'h01, 8'h02, 8'h03, 8'h04};
      rx_drain = 1'b1;
      drain(200);
      chk("rx_empty_after_4", 32'(rx_empty), 32'd1);
      rx = 1'b0;
      repeat (24) @(negedge clk);
      rx = 1'b1;
      repeat (2000) @(negedge clk);
      chk("rx_glitch", 32'(rx_empty), 32'd1);
      rx_exp.push_back(8'h3C);
      send_byte(8'h3C);
      drain(400);
      rx_drain = 1'b0;
      send_byte(8'h42);
      chk("rx_before_reset", 32'(rx_empty), 32'd0);
      write_byte(8'h99);
      repeat (300) @(negedge clk);
      reset_i = 1'b1;
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
      chk("midframe_tx", 32'(tx), 32'd1);
      chk("midframe_tx_full", 32'(tx_full), 32'd0);
      chk("midframe_rx_empty", 32'(rx_empty), 32'd1);
      rx_drain = 1'b1;
      repeat (2000) @(negedge clk);
      chk("post_reset_idle", 32'(tx), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
